// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: default sizes, the
// burst FSM state type and the wrapping pointer increment.
package fifo_arb_pkg;

   localparam int N_REQ_DEF     = 4;
   localparam int MAX_BURST_DEF = 4;
   localparam int STALL_W       = 16;
   // requester index width; wide enough for the largest legal N_REQ (8)
   localparam int IDX_W         = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } burst_state_t;

   // next requester index after p, wrapping from n-1 back to 0
   function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p, input int n);
      if (int'(p) + 1 >= n)
         return '0;
      else
         return p + IDX_W'(1);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or after base, wrapping.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] base,
   output logic [IDX_W-1:0] winner,
   output logic             valid
);

   // scan offsets from the far end so the smallest offset from base wins
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && (i == (int'(base) + k) % N_REQ)) begin
               winner = IDX_W'(i);
               valid  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for N requesters sharing one FIFO write port.
// Optional burst mode (macro FIFO_ARB_BURST_EN) lets one requester keep
// the port for up to MAX_BURST consecutive grants.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ      = N_REQ_DEF,
   parameter int FIFO_WIDTH = 16,
   parameter int MAX_BURST  = MAX_BURST_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
   input  logic                        fifo_full,
   input  logic                        fifo_almostfull,
   output logic                        fifo_wr_en,
   output logic [FIFO_WIDTH-1:0]       fifo_data_in,
   output logic [N_REQ-1:0]            gnt,
   output logic [STALL_W-1:0]          stall_cnt
);

   logic [IDX_W-1:0]      rr_ptr, rr_ptr_nxt;
   logic [IDX_W-1:0]      pick_base, pick_winner, win_idx;
   logic                  pick_valid, issue;
   logic [N_REQ-1:0]      gnt_nxt;
   logic [FIFO_WIDTH-1:0] data_nxt;

   // the write already in flight counts against an almost-full FIFO
   assign issue = pick_valid && !fifo_full && !(fifo_wr_en && fifo_almostfull);

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req    (req),
      .base   (pick_base),
      .winner (pick_winner),
      .valid  (pick_valid)
   );

`ifdef FIFO_ARB_BURST_EN
   // state | meaning
   // ST_IDLE  | no owner; next issue goes to the round-robin winner
   // ST_BURST | owner holds the port while requesting and bcnt < MAX_BURST
   localparam int BCNT_W = $clog2(MAX_BURST + 1);

   burst_state_t      state, state_nxt;
   logic [IDX_W-1:0]  owner, owner_nxt;
   logic [BCNT_W-1:0] bcnt, bcnt_nxt;
   logic              owner_req, burst_end;

   // request line of the current owner
   always_comb begin
      owner_req = 1'b0;
      for (int i = 0; i < N_REQ; i++)
         if (owner == IDX_W'(i)) owner_req = req[i];
   end

   assign burst_end = (state == ST_BURST) && (!owner_req || bcnt == BCNT_W'(MAX_BURST));
   // on burst end the port is handed on in the same cycle, scanning past the owner
   assign pick_base = burst_end ? ptr_inc(owner, N_REQ) : rr_ptr;
   assign win_idx   = (state == ST_BURST && !burst_end) ? owner : pick_winner;

   // burst FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         owner <= '0;
         bcnt  <= '0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         bcnt  <= bcnt_nxt;
      end
   end

   // burst FSM next state; stalls on full keep the burst without counting
   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      bcnt_nxt   = bcnt;
      rr_ptr_nxt = rr_ptr;
      case (state)
         ST_IDLE: begin
            if (issue) begin
               state_nxt = ST_BURST;
               owner_nxt = win_idx;
               bcnt_nxt  = BCNT_W'(1);
            end
         end
         ST_BURST: begin
            if (burst_end) begin
               rr_ptr_nxt = ptr_inc(owner, N_REQ);
               if (issue) begin
                  owner_nxt = win_idx;
                  bcnt_nxt  = BCNT_W'(1);
               end else begin
                  state_nxt = ST_IDLE;
                  bcnt_nxt  = '0;
               end
            end else if (issue) begin
               bcnt_nxt = bcnt + BCNT_W'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end
`else
   assign pick_base = rr_ptr;
   assign win_idx   = pick_winner;

   // pointer moves just past each winner
   always_comb begin
      rr_ptr_nxt = rr_ptr;
      if (issue) rr_ptr_nxt = ptr_inc(win_idx, N_REQ);
   end
`endif

   // one-hot grant and data mux for the selected requester
   always_comb begin
      gnt_nxt  = '0;
      data_nxt = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_idx == IDX_W'(i)) begin
            gnt_nxt[i] = 1'b1;
            data_nxt   = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
         end
      end
   end

   // registered write port, pointer and stall counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt          <= '0;
         fifo_wr_en   <= 1'b0;
         fifo_data_in <= '0;
         rr_ptr       <= '0;
         stall_cnt    <= '0;
      end else begin
         rr_ptr <= rr_ptr_nxt;
         if (issue) begin
            gnt          <= gnt_nxt;
            fifo_wr_en   <= 1'b1;
            fifo_data_in <= data_nxt;
         end else begin
            gnt        <= '0;
            fifo_wr_en <= 1'b0;
         end
         if (pick_valid && !issue && stall_cnt != '1)
            stall_cnt <= stall_cnt + STALL_W'(1);
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (default build; burst expectations
// selected when FIFO_ARB_BURST_EN is defined).
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int W  = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N*W-1:0] req_data;
   logic           fifo_full;
   logic           fifo_almostfull;
   logic           fifo_wr_en;
   logic [W-1:0]   fifo_data_in;
   logic [N-1:0]   gnt;
   logic [15:0]    stall_cnt;

   int n_vec = 0;
   int n_bad = 0;

   fifo_wr_arbiter #(.N_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req             (req),
      .req_data        (req_data),
      .fifo_full       (fifo_full),
      .fifo_almostfull (fifo_almostfull),
      .fifo_wr_en      (fifo_wr_en),
      .fifo_data_in    (fifo_data_in),
      .gnt             (gnt),
      .stall_cnt       (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // advance one clock; outputs sampled 1ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   logic [N-1:0] exp_seq [0:8];

   initial begin
      rst_n           = 1'b0;
      req             = '0;
      fifo_full       = 1'b0;
      fifo_almostfull = 1'b0;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(16'h1000 + i);
      #12;

      // reset state
      chk("rst_gnt",   32'(gnt),          32'h0);
      chk("rst_wr_en", 32'(fifo_wr_en),   32'h0);
      chk("rst_data",  32'(fifo_data_in), 32'h0);
      chk("rst_stall", 32'(stall_cnt),    32'h0);

`ifdef FIFO_ARB_BURST_EN
      // burst: two requesters, four grants each
      exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                  4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
      req = 4'b0011;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 9; c++) begin
         step();
         chk($sformatf("burst_gnt%0d", c), 32'(gnt), 32'(exp_seq[c]));
      end
`else
      // all requesting: plain rotation
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                  4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      req = 4'b1111;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         chk($sformatf("rr_gnt%0d", c),   32'(gnt),          32'(exp_seq[c]));
         chk($sformatf("rr_data%0d", c),  32'(fifo_data_in), 32'h1000 + 32'(c % 4));
         chk($sformatf("rr_wr_en%0d", c), 32'(fifo_wr_en),   32'h1);
      end
`endif

      // full for 5 cycles, then released
      do_reset();
      req       = 4'b0100;
      fifo_full = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("full_wr_en", 32'(fifo_wr_en), 32'h0);
      end
      chk("full_stall", 32'(stall_cnt), 32'd5);
      fifo_full = 1'b0;
      step();
      chk("full_rel_gnt",   32'(gnt),        32'b0100);
      chk("full_rel_wr",    32'(fifo_wr_en), 32'h1);
      chk("full_rel_stall", 32'(stall_cnt),  32'd5);

      // almost full blocks the write right after one in flight
      req = 4'b0000;
      do_reset();
      req             = 4'b0001;
      fifo_almostfull = 1'b1;
      step();
      chk("af_wr1", 32'(fifo_wr_en), 32'h1);
      step();
      chk("af_wr2", 32'(fifo_wr_en), 32'h0);
      chk("af_gnt2", 32'(gnt), 32'h0);
      step();
      chk("af_wr3", 32'(fifo_wr_en), 32'h1);
      chk("af_stall", 32'(stall_cnt), 32'd1);
      fifo_almostfull = 1'b0;

      // data path for requester 2, then hold with no request
      req = 4'b0000;
      do_reset();
      req_data[2*W +: W] = 16'hA5A5;
      req = 4'b0100;
      step();
      chk("data_val", 32'(fifo_data_in), 32'hA5A5);
      chk("data_gnt", 32'(gnt),          32'b0100);
      chk("data_wr",  32'(fifo_wr_en),   32'h1);
      req = 4'b0000;
      step();
      chk("hold_wr",   32'(fifo_wr_en),   32'h0);
      chk("hold_data", 32'(fifo_data_in), 32'hA5A5);

      // reset mid-stream, then restart from index 0
      req = 4'b1111;
      step();
      step();
      chk("mid_wr_pre", 32'(fifo_wr_en), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_gnt",   32'(gnt),          32'h0);
      chk("mid_wr",    32'(fifo_wr_en),   32'h0);
      chk("mid_data",  32'(fifo_data_in), 32'h0);
      req = 4'b1010;
      #1;
      rst_n = 1'b1;
      step();
      chk("post_gnt1", 32'(gnt), 32'b0010);
`ifdef FIFO_ARB_BURST_EN
      step();
      chk("post_gnt2", 32'(gnt), 32'b0010);
`else
      step();
      chk("post_gnt2", 32'(gnt), 32'b1000);
      step();
      chk("post_gnt3", 32'(gnt), 32'b0010);
`endif

      // stall counter saturation
      req = 4'b0000;
      do_reset();
      req       = 4'b0001;
      fifo_full = 1'b1;
      repeat (65540) @(posedge clk);
      #1;
      chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
      fifo_full = 1'b0;
      step();
      chk("stall_sat_hold", 32'(stall_cnt), 32'hFFFF);
      chk("stall_sat_gnt",  32'(gnt),       32'b0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
